pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It replaces the static stall generator. It merges hazard requests from the stages into the shared stall bus:
- load-use from ID,
- multi-cycle divide from EX,
- data-SRAM wait and exceptions from MEM.

It also owns the divide cycle counter, flush/redirect generation and per-cause stall performance counters.

Parameters:
STALL_W, 6, stall bus width; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
DIV_CYCLES, 32, total stall cycles per divide (legal range 2..255).
EXC_VEC, 32'hBFC00380, redirect PC driven on flush.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
stallreq_id  in  1  load-use hazard detected in ID this cycle.
ex_div_req  in  1  EX holds a div/divu; held high until EX advances.
mem_wait  in  1  data SRAM not ready; MEM must hold.
excp_valid  in  1  MEM reports an exception this cycle (one-cycle pulse).
stall  out  STALL_W  hold/bubble vector; stall[i]=1 and stall[i+1]=0 injects a bubble into stage i+1.
flush  out  1  kill IF/ID, ID/EX and EX/MEM contents.
new_pc  out  32  redirect target; valid when flush=1.
div_done  out  1  divide result valid in EX this cycle.
cnt_load_use  out  32  cycles stalled for load-use.
cnt_div  out  32  cycles stalled for divide.
cnt_mem_wait  out  32  cycles stalled for mem_wait.

Behaviour:
Reset and state:
- While rst=1: state=IDLE, div counter=0, all perf counters=0.
- While rst=1: stall=0, flush=0, new_pc=0, div_done=0.
- Reset mid-divide aborts the divide; no div_done is produced.
- FSM states: IDLE, DIV_WAIT. div counter dcnt is 8 bits.

Stall and flush outputs:
- stall, flush, new_pc and div_done are combinational from state, dcnt and inputs (zero-latency).
- Only the FSM, dcnt and the perf counters are registered.

Priority, evaluated every cycle (highest first):
1. excp_valid=1:
   - flush=1, new_pc=EXC_VEC, stall=6'b000000, div_done=0.
   - Next state IDLE, dcnt<=0. Any divide in progress is aborted.
   - No perf counter increments.
2. mem_wait=1:
   - stall=6'b011111; cnt_mem_wait++.
   - FSM and dcnt still advance as described below, so the divider runs in parallel.
3. state=DIV_WAIT and dcnt!=0:
   - stall=6'b001111; cnt_div++.
4. state=IDLE and ex_div_req=1:
   - stall=6'b001111; cnt_div++.
5. stallreq_id=1:
   - stall=6'b000111 (bubble into EX); cnt_load_use++.
6. Otherwise stall=0.

Divide sequencing:
- IDLE, ex_div_req=1 and excp_valid=0: go to DIV_WAIT, dcnt<=DIV_CYCLES-1. This request cycle is stall cycle 1.
- DIV_WAIT, dcnt!=0: dcnt<=dcnt-1.
- DIV_WAIT, dcnt==0: div_done=1.
  - If mem_wait=0: stall from divide released, next state IDLE, EX advances this edge.
  - If mem_wait=1: remain in DIV_WAIT with dcnt=0 and div_done held high until mem_wait falls.
- Result: with no mem_wait, stall is asserted for exactly DIV_CYCLES consecutive cycles and div_done is asserted in cycle DIV_CYCLES+1.
- Back-to-back divides: ex_div_req seen high in IDLE on the cycle after div_done starts a new divide.
- stallreq_id is ignored (not counted) while a divide stall or mem_wait stall is active. ID is already held in those cases.

Perf counters:
- 32-bit, wrap modulo 2^32.
- At most one counter increments per cycle, selected by the priority above.

Test Plan:
1. Reset: assert rst mid-run with ex_div_req=1 and state DIV_WAIT -> all outputs 0 immediately (async). After release with no requests: stall=0 and counters=0.
2. Load-use: stallreq_id=1 for one cycle -> stall=6'b000111 that cycle only; cnt_load_use=1; flush=0.
3. Divide (DIV_CYCLES=32): ex_div_req rises at T0 -> stall=6'b001111 for T0..T31; div_done=1 and stall=0 at T32; cnt_div=32; state IDLE at T33.
4. Divide + mem_wait: mem_wait=1 from T30 to T35 -> stall=6'b011111 over T30..T35; div_done=1 over T32..T36; exit to IDLE after T36. cnt_div=30, cnt_mem_wait=6.
5. Exception mid-divide: excp_valid pulse at T10 -> flush=1, new_pc=32'hBFC00380, stall=0 at T10; state IDLE at T11; no div_done ever pulses; cnt_div=10.
6. Counter wrap: force cnt_load_use=32'hFFFFFFFF, then one load-use cycle -> counter reads 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, divide,
// data-SRAM wait and exception requests into one stall bus plus perf counters.
module pipe_stall_ctrl #(
  parameter int          STALL_W    = 6,
  parameter int          DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_div_req,
  input  logic               mem_wait,
  input  logic               excp_valid,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               div_done,
  output logic [31:0]        cnt_load_use,
  output logic [31:0]        cnt_div,
  output logic [31:0]        cnt_mem_wait
);

  typedef enum logic {IDLE, DIV_WAIT} state_t;
  typedef enum logic [1:0] {INC_NONE, INC_LU, INC_DIV, INC_MEM} inc_t;

  localparam logic [7:0]         DIV_LOAD   = 8'(DIV_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_DIV  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_LU   = STALL_W'(6'b000111);

  state_t     state, state_nxt;
  logic [7:0] dcnt, dcnt_nxt;
  inc_t       inc_sel;
  logic       div_busy;

  // Divide stall holds while counting down, or on the first request cycle.
  assign div_busy = ((state == DIV_WAIT) && (dcnt != 8'd0)) ||
                    ((state == IDLE) && ex_div_req);

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    stall     = '0;
    flush     = 1'b0;
    new_pc    = 32'd0;
    div_done  = 1'b0;
    inc_sel   = INC_NONE;
    // Outputs are gated during reset so they drop without waiting for a clock.
    if (!rst) begin
      if (excp_valid) begin
        flush     = 1'b1;
        new_pc    = EXC_VEC;
        state_nxt = IDLE;
        dcnt_nxt  = 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (ex_div_req) begin
              state_nxt = DIV_WAIT;
              dcnt_nxt  = DIV_LOAD;
            end
          end
          DIV_WAIT: begin
            if (dcnt != 8'd0) begin
              dcnt_nxt = dcnt - 8'd1;
            end else begin
              div_done = 1'b1;
              if (!mem_wait) state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase

        // The divider keeps counting underneath a mem_wait stall.
        if (mem_wait) begin
          stall   = STALL_MEM;
          inc_sel = INC_MEM;
        end else if (div_busy) begin
          stall   = STALL_DIV;
          inc_sel = INC_DIV;
        end else if (stallreq_id) begin
          stall   = STALL_LU;
          inc_sel = INC_LU;
        end
      end
    end
  end

  // Stage boundary: FSM, divide counter and per-cause perf counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dcnt         <= 8'd0;
      cnt_load_use <= 32'd0;
      cnt_div      <= 32'd0;
      cnt_mem_wait <= 32'd0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      case (inc_sel)
        INC_LU:  cnt_load_use <= cnt_load_use + 32'd1;
        INC_DIV: cnt_div      <= cnt_div + 32'd1;
        INC_MEM: cnt_mem_wait <= cnt_mem_wait + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, load-use, divide, divide under
// mem_wait, exception abort, async reset mid-divide and counter wrap.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, ex_div_req, mem_wait, excp_valid;
  logic [5:0]  stall;
  logic        flush, div_done;
  logic [31:0] new_pc, cnt_load_use, cnt_div, cnt_mem_wait;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .ex_div_req(ex_div_req),
    .mem_wait(mem_wait), .excp_valid(excp_valid),
    .stall(stall), .flush(flush), .new_pc(new_pc), .div_done(div_done),
    .cnt_load_use(cnt_load_use), .cnt_div(cnt_div), .cnt_mem_wait(cnt_mem_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stallreq_id = 1'b0; ex_div_req = 1'b0; mem_wait = 1'b0; excp_valid = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [5:0] exp_st;
  logic       exp_dd;
  int         dd_seen;

  initial begin
    clr_in();
    rst = 1'b1;
    #3;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_divdone", 32'(div_done), 32'h0);
    cyc();
    rst = 1'b0;
    #4;
    chk("idle_stall", 32'(stall), 32'h0);
    chk("idle_cnts", cnt_load_use | cnt_div | cnt_mem_wait, 32'h0);

    // Load-use for one cycle
    cyc();
    stallreq_id = 1'b1;
    #4;
    chk("lu_stall", 32'(stall), 32'h07);
    chk("lu_flush", 32'(flush), 32'h0);
    cyc();
    stallreq_id = 1'b0;
    #4;
    chk("lu_stall_off", 32'(stall), 32'h0);
    chk("lu_cnt", cnt_load_use, 32'd1);

    // Plain divide: stall T0..T31, div_done at T32
    do_reset();
    ex_div_req = 1'b1;
    for (int t = 0; t <= 32; t++) begin
      #4;
      exp_st = (t < 32) ? 6'b001111 : 6'b000000;
      exp_dd = (t == 32);
      chk($sformatf("div_stall_T%0d", t), 32'(stall), 32'(exp_st));
      chk($sformatf("div_done_T%0d", t), 32'(div_done), 32'(exp_dd));
      cyc();
    end
    ex_div_req = 1'b0;
    #4;
    chk("div_T33_stall", 32'(stall), 32'h0);
    chk("div_T33_done", 32'(div_done), 32'h0);
    chk("div_cnt", cnt_div, 32'd32);

    // Divide with mem_wait over T30..T35
    do_reset();
    ex_div_req = 1'b1;
    for (int t = 0; t <= 36; t++) begin
      mem_wait = (t >= 30 && t <= 35);
      #4;
      exp_st = (t < 30) ? 6'b001111 : (t <= 35) ? 6'b011111 : 6'b000000;
      exp_dd = (t >= 32 && t <= 36);
      chk($sformatf("dmw_stall_T%0d", t), 32'(stall), 32'(exp_st));
      chk($sformatf("dmw_done_T%0d", t), 32'(div_done), 32'(exp_dd));
      cyc();
    end
    clr_in();
    #4;
    chk("dmw_T37_done", 32'(div_done), 32'h0);
    chk("dmw_cnt_div", cnt_div, 32'd30);
    chk("dmw_cnt_mem", cnt_mem_wait, 32'd6);

    // Exception at T10 aborts a divide
    do_reset();
    ex_div_req = 1'b1;
    for (int t = 0; t < 10; t++) cyc();
    excp_valid = 1'b1;
    #4;
    chk("exc_flush", 32'(flush), 32'h1);
    chk("exc_newpc", new_pc, 32'hBFC00380);
    chk("exc_stall", 32'(stall), 32'h0);
    chk("exc_divdone", 32'(div_done), 32'h0);
    cyc();
    clr_in();
    dd_seen = 0;
    for (int t = 0; t < 40; t++) begin
      #4;
      if (div_done) dd_seen++;
      cyc();
    end
    chk("exc_no_divdone", 32'(dd_seen), 32'd0);
    chk("exc_cnt_div", cnt_div, 32'd10);
    chk("exc_flush_off", 32'(flush), 32'h0);

    // Async reset in the middle of a divide
    do_reset();
    ex_div_req = 1'b1;
    for (int t = 0; t < 5; t++) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_divdone", 32'(div_done), 32'h0);
    chk("arst_cnt_div", cnt_div, 32'h0);
    cyc();
    clr_in();
    rst = 1'b0;
    dd_seen = 0;
    for (int t = 0; t < 40; t++) begin
      #4;
      if (div_done || stall != 6'b0) dd_seen++;
      cyc();
    end
    chk("arst_quiet", 32'(dd_seen), 32'd0);
    chk("arst_cnts", cnt_load_use | cnt_div | cnt_mem_wait, 32'h0);

    // Load-use counter wraps
    force dut.cnt_load_use = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_load_use;
    stallreq_id = 1'b1;
    cyc();
    stallreq_id = 1'b0;
    #4;
    chk("lu_wrap", cnt_load_use, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
